// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - frame-buffer RAM arbiter, VGA priority reads plus CPU port
// Fixed two-stage tag pipeline returns data on the cycle after edge k+2.
module fb_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic [15:0]           vga_data,
  output logic                  vga_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]           cpu_wdata,
  output logic                  cpu_ack,
  output logic [15:0]           cpu_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic [WAIT_WIDTH-1:0] cpu_wait_max
);

  typedef enum logic [1:0] {C_IDLE, C_PEND, C_FLIGHT, C_DONE} cpu_state_t;
  typedef enum logic [1:0] {T_NONE, T_VGA, T_CPU} tag_t;

  cpu_state_t r_state;
  cpu_state_t w_next_state;
  tag_t       r_tag1;
  tag_t       r_tag2;
  logic       r_we2;
  logic       w_cpu_issue;

  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic [15:0]           r_mem_wdata;
  logic [15:0]           r_vga_data;
  logic [15:0]           r_cpu_rdata;
  logic                  r_vga_valid;
  logic                  r_cpu_ack;
  logic [WAIT_WIDTH-1:0] r_wait;
  logic [WAIT_WIDTH-1:0] r_wait_max;

  assign w_cpu_issue = !vga_req && (r_state == C_PEND);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE:   if (cpu_req) w_next_state = C_PEND;
      C_PEND:   if (w_cpu_issue) w_next_state = C_FLIGHT;
      C_FLIGHT: w_next_state = C_DONE;
      C_DONE:   w_next_state = C_IDLE;
      default:  w_next_state = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= C_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_tag1      <= T_NONE;
      r_tag2      <= T_NONE;
      r_we2       <= 1'b0;
      r_vga_data  <= '0;
      r_vga_valid <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
    end else begin
      if (vga_req) begin
        r_mem_addr <= vga_addr;
        r_mem_we   <= 1'b0;
        r_tag1     <= T_VGA;
      end else if (r_state == C_PEND) begin
        r_mem_addr  <= cpu_addr;
        r_mem_we    <= cpu_we;
        r_mem_wdata <= cpu_wdata;
        r_tag1      <= T_CPU;
      end else begin
        r_mem_we <= 1'b0;
        r_tag1   <= T_NONE;
      end
      // Stage 2 lines up with the RAM output of the slot issued two edges ago.
      r_tag2      <= r_tag1;
      r_we2       <= r_mem_we;
      r_vga_valid <= (r_tag2 == T_VGA);
      r_cpu_ack   <= (r_tag2 == T_CPU);
      if (r_tag2 == T_VGA) r_vga_data <= mem_rdata;
      if (r_tag2 == T_CPU && !r_we2) r_cpu_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait     <= '0;
      r_wait_max <= '0;
    end else if (r_state == C_IDLE && cpu_req) begin
      r_wait <= '0;
    end else if (r_state == C_PEND) begin
      if (w_cpu_issue) begin
        if (r_wait > r_wait_max) r_wait_max <= r_wait;
      end else if (r_wait != '1) begin
        r_wait <= r_wait + WAIT_WIDTH'(1);
      end
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_we       = r_mem_we;
  assign mem_wdata    = r_mem_wdata;
  assign vga_data     = r_vga_data;
  assign vga_valid    = r_vga_valid;
  assign cpu_rdata    = r_cpu_rdata;
  assign cpu_ack      = r_cpu_ack;
  assign cpu_wait_max = r_wait_max;

endmodule
